// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode hex display driver.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_en,
`ifdef SEG7_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tc;
    logic                  boundary;

    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     disp_dp;
    logic [4*DIGITS-1:0]   stage_val;
    logic [DIGITS-1:0]     stage_dp;
    logic                  pending;

    logic [DIGITS-1:0]     zero_from;
    logic [DIGITS-1:0]     blank_vec;
    logic [DIGITS-1:0]     an_d;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank_cur;
    logic                  dark_cur;

    assign tc       = (cnt == CNT_MAX);
    assign boundary = tc && (idx == IDX_MAX);

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Prescaler: sets the dwell time of each digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index advances on each prescaler wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tc) begin
            if (idx == IDX_MAX) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Staging and display registers; display only changes at frame edges.
    // A load in the boundary cycle bypasses staging, leaving the old
    // staged value untouched but no longer pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_val  <= '0;
            disp_dp   <= '0;
            stage_val <= '0;
            stage_dp  <= '0;
            pending   <= 1'b0;
        end else if (boundary) begin
            pending <= 1'b0;
            if (load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
            end else if (pending) begin
                disp_val <= stage_val;
                disp_dp  <= stage_dp;
            end
        end else if (load) begin
            stage_val <= value;
            stage_dp  <= dp_in;
            pending   <= 1'b1;
        end
    end

    // Leading-zero map: zero_from[k] means nibbles k..top are all zero
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        blank_vec = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run          = run && (disp_val[4*k +: 4] == 4'h0);
            zero_from[k] = run;
        end
        for (int k = 1; k < DIGITS; k++) begin
            blank_vec[k] = blank_en && zero_from[k];
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FC_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt;
    logic          phase;

    // Frame counter toggles the blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (boundary) begin
            if (fcnt == FC_MAX) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
`endif

    // Select the active digit's nibble, dp and suppression flags
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        blank_cur = 1'b0;
        dark_cur  = 1'b0;
        an_d      = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = disp_val[4*k +: 4];
                dp_bit    = disp_dp[k];
                blank_cur = blank_vec[k];
`ifdef SEG7_BLINK_EN
                dark_cur  = phase && blink_mask[k];
`endif
                an_d[k]   = 1'b0;
            end
        end
    end

    // Registered pin drivers, one cycle behind idx and display
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            an_n       <= an_d;
            if (blank_cur || dark_cur) begin
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end else begin
                seg_n <= hex7(nib);
                dp_n  <= ~dp_bit;
            end
        end
    end

endmodule
